shared_compare_scheduler: RTL and testbench
===========================================

Name: shared_compare_scheduler

Overview:
- Round-robin scheduler that shares one bit-serial magnitude-compare engine among NREQ requesters.
- Each requester offers an unsigned operand pair (a, b) on a valid/ready handshake.
- The block grants one requester, then evaluates MSB-first, one bit per cycle, using the standard greater/equal/smaller cascade with early exit.
- It returns a tagged g/e/s result on a valid/ready response channel. It sits between compare clients and downstream consumers, replacing one parallel comparator per client.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester id; must equal clog2(NREQ).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester operand pair valid.
- req_ready  output  NREQ  per-requester grant/accept, at most one bit high.
- req_a  input  NREQ*WIDTH  operand a; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand b, same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of the requester the result belongs to.
- rsp_g  output  1  a > b.
- rsp_e  output  1  a == b.
- rsp_s  output  1  a < b.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Async reset (rst_n low), effective immediately:
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_g=rsp_e=rsp_s=0; rsp_id=0; busy=0.
  - RR pointer=NREQ-1, so requester 0 has top priority first.
  - Any in-flight comparison is discarded and no response is issued.
- States: IDLE, SHIFT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from pointer+1 upward modulo NREQ.
  - req_ready[winner]=1, combinational from req_valid and the pointer; all other req_ready bits are 0.
  - On the clock edge with valid & ready:
    - Capture that requester's a and b into internal registers; capture id.
    - Pointer := winner.
    - Flags (g,e,s) := (0,1,0); bit index := WIDTH-1; go to SHIFT.
  - No request: stay in IDLE. A requester may drop valid before it is granted; nothing is captured.
- SHIFT, one bit per cycle at the current index, using the one-bit cascade:
  - g'=g|(e&a[i]&~b[i]); s'=s|(e&~a[i]&b[i]); e'=e&~(a[i]^b[i]).
  - If e'=0 or index=0: latch g',e',s' and id onto the rsp_* outputs, set rsp_valid=1, go to RESP.
  - Otherwise index-1 and stay in SHIFT.
  - req_ready is all zeros in SHIFT and RESP.
  - Input changes after acceptance have no effect.
- Latency:
  - Accept edge at cycle 0; SHIFT cycles k = WIDTH-d, where d is the index of the most significant differing bit; k = WIDTH if the operands are equal.
  - rsp_valid is high from cycle k+1.
  - Minimum latency 2 cycles (MSB differs); maximum WIDTH+1.
- RESP:
  - rsp_valid and all rsp_* outputs are held stable until the edge where rsp_ready=1, then go to IDLE and clear rsp_valid.
  - rsp_g/e/s retain their last values after rsp_valid drops.
  - Exactly one of rsp_g, rsp_e, rsp_s is high whenever rsp_valid=1.
  - No grant in the RESP cycle; the next grant is at the earliest one cycle after the response handshake. Throughput is therefore one compare per k+2 cycles.
- Simultaneous requests are resolved only by the RR pointer. A requester holding valid continuously is served at least once every NREQ grants.
- rsp_ready high while rsp_valid=0 is ignored.
- Operands are unsigned. WIDTH need not be a power of two; the index counter is clog2(WIDTH) bits.

Test Plan:
- Equal operands: req0 a=0xA5, b=0xA5, rsp_ready=1 → 8 SHIFT cycles; rsp_valid at cycle 9; e=1, g=s=0, id=0; busy high cycles 1–9.
- MSB early exit: req1 only, a=0x80, b=0x7F → 1 SHIFT cycle; rsp_valid at cycle 2; g=1, id=1.
- LSB decides: req2 a=0x12, b=0x13 → 8 SHIFT cycles; rsp_valid at cycle 9; s=1, id=2.
- Fairness: all four req_valid held high, distinct operands, rsp_ready=1 → grant order 0,1,2,3,0,1; exactly one req_ready bit high in each IDLE cycle, never high in SHIFT/RESP.
- Backpressure: req0 a=0x01, b=0x02; rsp_ready=0 for 5 cycles after rsp_valid rises, with req3 valid throughout → rsp_valid, s=1 and id=0 stable for all 5 cycles; req_ready=0; req3 granted one cycle after rsp_ready rises.
- Reset mid-op: rst_n low during the 4th SHIFT cycle of a=0x55, b=0x55 → all outputs 0 immediately without a clock edge; after release, requests from 0 and 2 together → req0 granted first, and no stale response ever appears.

Source files
------------

// File: rtl/shared_compare_scheduler.sv
// shared_compare_scheduler
//   Round-robin scheduler sharing one bit-serial, MSB-first magnitude comparator
//   among NREQ requesters. A granted operand pair is compared one bit per cycle
//   with early exit on the first differing bit; the tagged g/e/s result is
//   returned on a valid/ready response channel.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand pair valid
//   req_ready  per-requester grant/accept (one-hot or zero)
//   req_a      operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      operand b, same packing
//   rsp_valid  result valid
//   rsp_ready  consumer accepts result
//   rsp_id     requester index of the result
//   rsp_g      a > b
//   rsp_e      a == b
//   rsp_s      a < b
//   busy       state is not idle
module shared_compare_scheduler #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic                  rsp_g,
   output logic                  rsp_e,
   output logic                  rsp_s,
   output logic                  busy
);

   localparam int unsigned IW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StShift, StResp} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   cand;
   logic             any_valid;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IDW-1:0]   id_q;
   logic [IW-1:0]    idx_q;
   logic             g_q, e_q, s_q;
   logic             g_n, e_n, s_n;
   logic             ab, bb;
   logic             done;
   logic             accept;
   logic             rsp_valid_q, rsp_g_q, rsp_e_q, rsp_s_q;
   logic [IDW-1:0]   rsp_id_q;

   // Search starts just above the last winner so a continuously valid
   // requester waits at most NREQ-1 other grants.
   always_comb begin
      win       = '0;
      cand      = '0;
      any_valid = 1'b0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         cand = IDW'((int'(ptr_q) + k) % int'(NREQ));
         if (!any_valid && req_valid[cand]) begin
            any_valid = 1'b1;
            win       = cand;
         end
      end
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (win == IDW'(i)) begin
            a_sel = req_a[i*WIDTH +: WIDTH];
            b_sel = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // One step of the greater/equal/smaller cascade at the current bit.
   assign ab     = a_q[idx_q];
   assign bb     = b_q[idx_q];
   assign g_n    = g_q | (e_q & ab & ~bb);
   assign s_n    = s_q | (e_q & ~ab & bb);
   assign e_n    = e_q & ~(ab ^ bb);
   assign done   = ~e_n | (idx_q == '0);
   assign accept = (state_q == StIdle) & any_valid;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any_valid) state_d = StShift;
         StShift: if (done) state_d = StResp;
         StResp:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs; the grant is held off while reset is asserted.
   always_comb begin
      req_ready = '0;
      busy      = (state_q != StIdle);
      if (rst_n && (state_q == StIdle) && any_valid) begin
         req_ready[win] = 1'b1;
      end
   end

   // Operand capture, serial compare and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= IDW'(NREQ - 1);
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         idx_q       <= '0;
         g_q         <= 1'b0;
         e_q         <= 1'b0;
         s_q         <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_g_q     <= 1'b0;
         rsp_e_q     <= 1'b0;
         rsp_s_q     <= 1'b0;
         rsp_id_q    <= '0;
      end else if (accept) begin
         a_q   <= a_sel;
         b_q   <= b_sel;
         id_q  <= win;
         ptr_q <= win;
         g_q   <= 1'b0;
         e_q   <= 1'b1;
         s_q   <= 1'b0;
         idx_q <= IW'(WIDTH - 1);
      end else if (state_q == StShift) begin
         g_q <= g_n;
         e_q <= e_n;
         s_q <= s_n;
         if (done) begin
            rsp_valid_q <= 1'b1;
            rsp_g_q     <= g_n;
            rsp_e_q     <= e_n;
            rsp_s_q     <= s_n;
            rsp_id_q    <= id_q;
         end else begin
            idx_q <= idx_q - IW'(1);
         end
      end else if ((state_q == StResp) && rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_g     = rsp_g_q;
   assign rsp_e     = rsp_e_q;
   assign rsp_s     = rsp_s_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shared_compare_scheduler.sv
// Directed bench for shared_compare_scheduler (WIDTH=8, NREQ=4).
module tb_shared_compare_scheduler;

   localparam int W = 8;
   localparam int N = 4;
   localparam int I = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [I-1:0]   rsp_id;
   logic           rsp_g, rsp_e, rsp_s;
   logic           busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   shared_compare_scheduler #(.WIDTH(W), .NREQ(N), .IDW(I)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_g     (rsp_g),
      .rsp_e     (rsp_e),
      .rsp_s     (rsp_s),
      .busy      (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[r*W +: W] = a;
      req_b[r*W +: W] = b;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      req_valid = '0;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   // Called in cycle 1 (just after the accept edge); returns the cycle in
   // which rsp_valid was first seen, or 40 on timeout.
   task automatic wait_rsp(output int cyc);
      cyc = 1;
      while (!rsp_valid && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b0;
      req_a = '0;
      req_b = '0;
      tick();
      vectors++;
      if ({busy, rsp_valid, req_ready} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got busy=%b vld=%b rdy=%b want all 0", busy, rsp_valid, req_ready);
      end
      vectors++;
      if ({rsp_g, rsp_e, rsp_s, rsp_id} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_rsp: got ges=%b%b%b id=%0d want 0", rsp_g, rsp_e, rsp_s, rsp_id);
      end
      req_valid = '0;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_equal();
      rsp_ready = 1'b1;
      set_req(0, 8'hA5, 8'hA5);
      req_valid = 4'b0001;
      #1;
      vectors++;
      if (req_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL eq_grant: got %b want 0001", req_ready);
      end
      tick();
      req_valid = '0;
      for (int c = 1; c <= 9; c++) begin
         if (c > 1) tick();
         vectors++;
         if (c < 9) begin
            if ({busy, rsp_valid, req_ready} !== 6'b100000) begin
               miscompares++;
               $display("FAIL eq_shift c%0d: got busy=%b vld=%b rdy=%b want 1,0,0000",
                        c, busy, rsp_valid, req_ready);
            end
         end else begin
            if ({busy, rsp_valid, rsp_g, rsp_e, rsp_s, rsp_id} !== 7'b1101000) begin
               miscompares++;
               $display("FAIL eq_rsp: got busy=%b vld=%b ges=%b%b%b id=%0d want 1,1,010,0",
                        busy, rsp_valid, rsp_g, rsp_e, rsp_s, rsp_id);
            end
         end
      end
      tick();
      vectors++;
      if ({busy, rsp_valid, rsp_e} !== 3'b001) begin
         miscompares++;
         $display("FAIL eq_after: got busy=%b vld=%b e=%b want 0,0,1", busy, rsp_valid, rsp_e);
      end
   endtask

   task automatic test_msb_exit();
      int cyc;
      set_req(1, 8'h80, 8'h7F);
      req_valid = 4'b0010;
      #1;
      vectors++;
      if (req_ready !== 4'b0010) begin
         miscompares++;
         $display("FAIL msb_grant: got %b want 0010", req_ready);
      end
      tick();
      req_valid = '0;
      wait_rsp(cyc);
      vectors++;
      if (cyc !== 2) begin
         miscompares++;
         $display("FAIL msb_latency: got %0d want 2", cyc);
      end
      vectors++;
      if ({rsp_g, rsp_e, rsp_s, rsp_id} !== 5'b10001) begin
         miscompares++;
         $display("FAIL msb_rsp: got ges=%b%b%b id=%0d want 100,1", rsp_g, rsp_e, rsp_s, rsp_id);
      end
      tick();
   endtask

   task automatic test_lsb_decides();
      int cyc;
      set_req(2, 8'h12, 8'h13);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      wait_rsp(cyc);
      vectors++;
      if (cyc !== 9) begin
         miscompares++;
         $display("FAIL lsb_latency: got %0d want 9", cyc);
      end
      vectors++;
      if ({rsp_g, rsp_e, rsp_s, rsp_id} !== 5'b00110) begin
         miscompares++;
         $display("FAIL lsb_rsp: got ges=%b%b%b id=%0d want 001,2", rsp_g, rsp_e, rsp_s, rsp_id);
      end
      tick();
   endtask

   task automatic test_fairness();
      logic [2:0] exp_ges [4];
      int cyc;
      int exp;
      logic [N-1:0] one;
      exp_ges[0] = 3'b001;
      exp_ges[1] = 3'b010;
      exp_ges[2] = 3'b100;
      exp_ges[3] = 3'b100;
      pulse_reset();
      rsp_ready = 1'b1;
      set_req(0, 8'h10, 8'h20);
      set_req(1, 8'h30, 8'h30);
      set_req(2, 8'h90, 8'h10);
      set_req(3, 8'h05, 8'h04);
      req_valid = 4'b1111;
      #1;
      for (int g = 0; g < 6; g++) begin
         exp = g % 4;
         one = 4'b0001 << exp;
         vectors++;
         if (req_ready !== one) begin
            miscompares++;
            $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, one);
         end
         tick();
         cyc = 1;
         while (!rsp_valid && cyc < 20) begin
            vectors++;
            if (req_ready !== 4'b0000) begin
               miscompares++;
               $display("FAIL rr_busy_rdy%0d: got %b want 0000", g, req_ready);
            end
            tick();
            cyc++;
         end
         vectors++;
         if ({rsp_valid, req_ready, rsp_id, rsp_g, rsp_e, rsp_s} !== {1'b1, 4'b0000, exp[1:0], exp_ges[exp]}) begin
            miscompares++;
            $display("FAIL rr_rsp%0d: got vld=%b rdy=%b id=%0d ges=%b%b%b want 1,0000,%0d,%b",
                     g, rsp_valid, req_ready, rsp_id, rsp_g, rsp_e, rsp_s, exp, exp_ges[exp]);
         end
         tick();
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      int cyc;
      pulse_reset();
      rsp_ready = 1'b0;
      set_req(0, 8'h01, 8'h02);
      set_req(3, 8'h44, 8'h44);
      req_valid = 4'b1001;
      #1;
      vectors++;
      if (req_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL bp_grant0: got %b want 0001", req_ready);
      end
      tick();
      req_valid = 4'b1000;
      wait_rsp(cyc);
      vectors++;
      if (cyc !== 8) begin
         miscompares++;
         $display("FAIL bp_latency: got %0d want 8", cyc);
      end
      for (int c = 0; c < 5; c++) begin
         if (c > 0) tick();
         vectors++;
         if ({rsp_valid, rsp_s, rsp_g, rsp_e, rsp_id, req_ready} !== {3'b110, 1'b0, 2'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got vld=%b ges=%b%b%b id=%0d rdy=%b want 1,001,0,0000",
                     c, rsp_valid, rsp_g, rsp_e, rsp_s, rsp_id, req_ready);
         end
      end
      rsp_ready = 1'b1;
      #1;
      vectors++;
      if ({rsp_valid, req_ready} !== 5'b10000) begin
         miscompares++;
         $display("FAIL bp_hs: got vld=%b rdy=%b want 1,0000", rsp_valid, req_ready);
      end
      tick();
      vectors++;
      if ({rsp_valid, req_ready} !== 5'b01000) begin
         miscompares++;
         $display("FAIL bp_grant3: got vld=%b rdy=%b want 0,1000", rsp_valid, req_ready);
      end
      tick();
      req_valid = '0;
      wait_rsp(cyc);
      vectors++;
      if ({cyc[5:0], rsp_id, rsp_g, rsp_e, rsp_s} !== {6'd9, 2'd3, 3'b010}) begin
         miscompares++;
         $display("FAIL bp_req3: got cyc=%0d id=%0d ges=%b%b%b want 9,3,010",
                  cyc, rsp_id, rsp_g, rsp_e, rsp_s);
      end
      tick();
   endtask

   task automatic test_reset_midop();
      int cyc;
      rsp_ready = 1'b1;
      set_req(0, 8'h55, 8'h55);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      tick();
      tick();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_busy: got %b want 1", busy);
      end
      rst_n = 1'b0;
      req_valid = 4'b0101;
      #1;
      vectors++;
      if ({busy, rsp_valid, req_ready, rsp_g, rsp_e, rsp_s, rsp_id} !== 11'b0) begin
         miscompares++;
         $display("FAIL mid_reset: got busy=%b vld=%b rdy=%b ges=%b%b%b id=%0d want 0",
                  busy, rsp_valid, req_ready, rsp_g, rsp_e, rsp_s, rsp_id);
      end
      set_req(0, 8'h03, 8'h01);
      set_req(2, 8'h00, 8'hFF);
      tick();
      tick();
      vectors++;
      if ({busy, rsp_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL mid_held: got busy=%b vld=%b want 0,0", busy, rsp_valid);
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (req_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL mid_grant0: got %b want 0001", req_ready);
      end
      tick();
      req_valid = 4'b0100;
      wait_rsp(cyc);
      vectors++;
      if ({cyc[5:0], rsp_id, rsp_g, rsp_e, rsp_s} !== {6'd8, 2'd0, 3'b100}) begin
         miscompares++;
         $display("FAIL mid_req0: got cyc=%0d id=%0d ges=%b%b%b want 8,0,100",
                  cyc, rsp_id, rsp_g, rsp_e, rsp_s);
      end
      tick();
      vectors++;
      if (req_ready !== 4'b0100) begin
         miscompares++;
         $display("FAIL mid_grant2: got %b want 0100", req_ready);
      end
      tick();
      req_valid = '0;
      wait_rsp(cyc);
      vectors++;
      if ({cyc[5:0], rsp_id, rsp_g, rsp_e, rsp_s} !== {6'd2, 2'd2, 3'b001}) begin
         miscompares++;
         $display("FAIL mid_req2: got cyc=%0d id=%0d ges=%b%b%b want 2,2,001",
                  cyc, rsp_id, rsp_g, rsp_e, rsp_s);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_equal();
      test_msb_exit();
      test_lsb_decides();
      test_fairness();
      test_backpressure();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
